// File: rtl/calc_core_seq.sv
// Front-panel calculator core: button synchronisers, operand latch,
// pending-operation FSM and registered display/flag outputs.

module calc_btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    input  logic warm,
    output logic press
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              armed_q;
    logic              armed_d;

    // A button held through reset must be seen released before it can fire.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], btn_n};
        prev_d  = sync_q[STAGES-1];
        armed_d = armed_q | (warm & sync_q[STAGES-1]);
    end

    assign press = armed_q & prev_q & ~sync_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

endmodule

module calc_core_seq #(
    parameter int WIDTH       = 8,
    parameter int MUL_EN      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             plus_n,
    input  logic             minus_n,
    input  logic             mul_n,
    input  logic             equal_n,
    input  logic             clear_n,
    output logic [WIDTH-1:0] disp_val,
    output logic             disp_blank,
    output logic             flag,
    output logic             op_pend,
    output logic [1:0]       op_code
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   cap_q;
    logic [WIDTH-1:0]   cap_d;
    logic [WIDTH-1:0]   disp_q;
    logic [WIDTH-1:0]   disp_d;
    logic [1:0]         op_q;
    logic [1:0]         op_d;
    logic               blank_q;
    logic               blank_d;
    logic               flag_q;
    logic               flag_d;
    logic               pend_q;
    logic               pend_d;
    logic [SYNC_STAGES-1:0] warm_q;
    logic [SYNC_STAGES-1:0] warm_d;

    logic [4:0]         btn_n_raw;
    logic [4:0]         press;
    logic               pl_p;
    logic               mi_p;
    logic               mu_p;
    logic               eq_p;
    logic               clr_p;
    logic               op_hit;
    logic [1:0]         new_op;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    logic               res_flag;

    assign btn_n_raw = {clear_n, equal_n, mul_n, minus_n, plus_n};

    // Synchroniser outputs only mean something once they have been refilled after reset.
    assign warm_d = {warm_q[SYNC_STAGES-2:0], 1'b1};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        calc_btn_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .btn_n(btn_n_raw[i]),
            .warm (warm_q[SYNC_STAGES-1]),
            .press(press[i])
        );
    end

    always_comb begin
        clr_p  = press[4];
        eq_p   = press[3] & ~clr_p;
        pl_p   = press[0] & ~clr_p & ~eq_p;
        mi_p   = press[1] & ~clr_p & ~eq_p & ~press[0];
        mu_p   = (MUL_EN != 0) & press[2] & ~clr_p & ~eq_p
                 & ~press[0] & ~press[1];
        op_hit = pl_p | mi_p | mu_p;
        if (pl_p) begin
            new_op = 2'b01;
        end else if (mi_p) begin
            new_op = 2'b10;
        end else begin
            new_op = 2'b11;
        end
    end

    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, in};
        diff = {1'b0, a_q} - {1'b0, in};
        prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, in};
        res      = a_q;
        res_flag = 1'b0;
        case (op_q)
            2'b01: begin
                res      = sum[WIDTH-1:0];
                res_flag = sum[WIDTH];
            end
            2'b10: begin
                res      = diff[WIDTH-1:0];
                res_flag = diff[WIDTH];
            end
            2'b11: begin
                res      = prod[WIDTH-1:0];
                res_flag = |prod[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cap_d   = cap_q;
        disp_d  = disp_q;
        op_d    = op_q;
        blank_d = blank_q;
        flag_d  = flag_q;
        pend_d  = pend_q;
        if (clr_p) begin
            state_d = ST_IDLE;
            a_d     = '0;
            op_d    = 2'b00;
            flag_d  = 1'b0;
            disp_d  = in;
            blank_d = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    disp_d  = in;
                    blank_d = 1'b0;
                    pend_d  = 1'b0;
                    if (op_hit) begin
                        a_d     = in;
                        op_d    = new_op;
                        blank_d = 1'b1;
                        pend_d  = 1'b1;
                        state_d = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (eq_p) begin
                        disp_d  = res;
                        flag_d  = res_flag;
                        cap_d   = in;
                        op_d    = 2'b00;
                        blank_d = 1'b0;
                        pend_d  = 1'b0;
                        state_d = ST_RESULT;
                    end else if (op_hit) begin
                        op_d = new_op;
                    end
                end
                ST_RESULT: begin
                    if (op_hit) begin
                        a_d     = disp_q;
                        op_d    = new_op;
                        blank_d = 1'b1;
                        pend_d  = 1'b1;
                        state_d = ST_PEND;
                    end else if (!eq_p && (in != cap_q)) begin
                        disp_d  = in;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    disp_d  = in;
                    blank_d = 1'b0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            cap_q   <= '0;
            disp_q  <= '0;
            op_q    <= 2'b00;
            blank_q <= 1'b0;
            flag_q  <= 1'b0;
            pend_q  <= 1'b0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cap_q   <= cap_d;
            disp_q  <= disp_d;
            op_q    <= op_d;
            blank_q <= blank_d;
            flag_q  <= flag_d;
            pend_q  <= pend_d;
            warm_q  <= warm_d;
        end
    end

    assign disp_val   = disp_q;
    assign disp_blank = blank_q;
    assign flag       = flag_q;
    assign op_pend    = pend_q;
    assign op_code    = op_q;

endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq: vector table plus multi-cycle sequences.

module tb_calc_core_seq;

    localparam logic [4:0] P = 5'h01;
    localparam logic [4:0] M = 5'h02;
    localparam logic [4:0] X = 5'h04;
    localparam logic [4:0] E = 5'h08;
    localparam logic [4:0] C = 5'h10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in;
    logic [4:0] btn_n;

    logic [7:0] d1_val, d0_val;
    logic       d1_blank, d0_blank;
    logic       d1_flag, d0_flag;
    logic       d1_pend, d0_pend;
    logic [1:0] d1_code, d0_code;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    calc_core_seq #(.WIDTH(8), .MUL_EN(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in(in),
        .plus_n(btn_n[0]), .minus_n(btn_n[1]), .mul_n(btn_n[2]),
        .equal_n(btn_n[3]), .clear_n(btn_n[4]),
        .disp_val(d1_val), .disp_blank(d1_blank), .flag(d1_flag),
        .op_pend(d1_pend), .op_code(d1_code)
    );

    calc_core_seq #(.WIDTH(8), .MUL_EN(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(in),
        .plus_n(btn_n[0]), .minus_n(btn_n[1]), .mul_n(btn_n[2]),
        .equal_n(btn_n[3]), .clear_n(btn_n[4]),
        .disp_val(d0_val), .disp_blank(d0_blank), .flag(d0_flag),
        .op_pend(d0_pend), .op_code(d0_code)
    );

    typedef struct {
        logic [7:0] a;
        logic [4:0] op;
        logic [1:0] code;
        logic [7:0] b;
        logic [7:0] r;
        logic       f;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [4:0] m);
        tick(3);
        btn_n = ~m;
        tick(3);
        btn_n = 5'h1F;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] val,
                           input logic blank, input logic f,
                           input logic pend, input logic [1:0] code);
        chk({nm, "_disp"},  d1_val, val);
        chk({nm, "_blank"}, {7'b0, d1_blank}, {7'b0, blank});
        chk({nm, "_flag"},  {7'b0, d1_flag}, {7'b0, f});
        chk({nm, "_pend"},  {7'b0, d1_pend}, {7'b0, pend});
        chk({nm, "_code"},  {6'b0, d1_code}, {6'b0, code});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int changes;
        logic [7:0] last;

        v[0] = '{8'hF0, P, 2'b01, 8'h20, 8'h10, 1'b1};
        v[1] = '{8'h03, M, 2'b10, 8'h05, 8'hFE, 1'b1};
        v[2] = '{8'h10, X, 2'b11, 8'h11, 8'h10, 1'b1};
        v[3] = '{8'h12, P, 2'b01, 8'h34, 8'h46, 1'b0};
        v[4] = '{8'h50, M, 2'b10, 8'h20, 8'h30, 1'b0};
        v[5] = '{8'h0F, X, 2'b11, 8'h11, 8'hFF, 1'b0};
        v[6] = '{8'hFF, P, 2'b01, 8'h01, 8'h00, 1'b1};
        v[7] = '{8'h07, M, 2'b10, 8'h07, 8'h00, 1'b0};

        rst_n = 1'b0;
        btn_n = 5'h1F;
        in    = 8'h05;
        tick(2);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        tick(1);
        chk_out("idle_follow", 8'h05, 1'b0, 1'b0, 1'b0, 2'b00);

        for (int i = 0; i < 8; i++) begin
            in = v[i].a;
            press(C);
            press(v[i].op);
            chk($sformatf("v%0d_blank", i), {7'b0, d1_blank}, 8'h01);
            chk($sformatf("v%0d_pend", i), {7'b0, d1_pend}, 8'h01);
            chk($sformatf("v%0d_code", i), {6'b0, d1_code},
                {6'b0, v[i].code});
            in = v[i].b;
            press(E);
            chk_out($sformatf("v%0d_res", i), v[i].r, 1'b0, v[i].f,
                    1'b0, 2'b00);
        end

        in = 8'h03;
        press(C);
        press(M);
        in = 8'h05;
        press(E);
        chk_out("sub_borrow", 8'hFE, 1'b0, 1'b1, 1'b0, 2'b00);
        press(P);
        chk_out("chain_pend", 8'hFE, 1'b1, 1'b1, 1'b1, 2'b01);
        in = 8'h02;
        press(E);
        chk_out("chain_res", 8'h00, 1'b0, 1'b1, 1'b0, 2'b00);

        press(P);
        in = 8'h07;
        tick(3);
        btn_n = ~E;
        changes = 0;
        last = d1_val;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (d1_val !== last) changes++;
            last = d1_val;
        end
        btn_n = 5'h1F;
        chk("hold_eq_changes", 8'(changes), 8'd1);
        chk_out("hold_eq_res", 8'h07, 1'b0, 1'b0, 1'b0, 2'b00);

        in = 8'h10;
        press(C);
        press(X);
        chk("mul1_pend", {7'b0, d1_pend}, 8'h01);
        chk("mul1_code", {6'b0, d1_code}, 8'h03);
        chk("mul0_pend", {7'b0, d0_pend}, 8'h00);
        chk("mul0_blank", {7'b0, d0_blank}, 8'h00);
        in = 8'h11;
        press(E);
        chk_out("mul1_res", 8'h10, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("mul0_disp", d0_val, 8'h11);
        chk("mul0_code", {6'b0, d0_code}, 8'h00);

        in = 8'h09;
        press(C);
        press(M);
        in = 8'h04;
        press(P | E);
        chk_out("prio_eq", 8'h05, 1'b0, 1'b0, 1'b0, 2'b00);

        in = 8'h30;
        press(C);
        press(P);
        in = 8'h11;
        press(M);
        chk_out("replace", 8'h30, 1'b1, 1'b0, 1'b1, 2'b10);
        in = 8'h10;
        press(E);
        chk_out("replace_res", 8'h20, 1'b0, 1'b0, 1'b0, 2'b00);
        press(M);
        in = 8'h30;
        press(E);
        chk_out("chain_borrow", 8'hF0, 1'b0, 1'b1, 1'b0, 2'b00);
        press(M);
        press(C | E);
        chk_out("clr_eq", 8'h30, 1'b0, 1'b0, 1'b0, 2'b00);

        in = 8'h7F;
        press(C);
        press(P);
        tick(3);
        btn_n = ~E;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        tick(20);
        chk_out("rst_eq_held", 8'h7F, 1'b0, 1'b0, 1'b0, 2'b00);
        btn_n = 5'h1F;

        tick(2);
        btn_n = ~P;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(20);
        chk_out("rst_pl_held", 8'h7F, 1'b0, 1'b0, 1'b0, 2'b00);
        btn_n = 5'h1F;
        press(P);
        chk_out("repress_pl", 8'h7F, 1'b1, 1'b0, 1'b1, 2'b01);
        in = 8'h01;
        press(E);
        chk_out("repress_res", 8'h80, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
